// File: rtl/fa_attendant_panel.sv
// rtl/fa_attendant_panel.sv - attendant-station call queue for flight-attendant seat call units
// Queues seat light rises in arrival order, presents the oldest, pulses cancel on ack, waits for the light to drop.
module fa_attendant_panel #(
    parameter int NUM_SEATS = 8,
    parameter int SEAT_W    = 3,
    parameter int WAIT_MAX  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SEATS-1:0] light_state,
    input  logic                 ack_button,
    output logic [NUM_SEATS-1:0] cancel_pulse,
    output logic [SEAT_W-1:0]    current_seat,
    output logic                 current_valid,
    output logic [SEAT_W:0]      pending_count,
    output logic                 chime,
    output logic                 stuck_fault
);

    localparam int TMR_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_CANCEL,
        S_WAIT_CLR,
        S_RETIRE
    } state_t;

    state_t               r_state;
    logic [NUM_SEATS-1:0] r_prev;
    logic [NUM_SEATS-1:0] r_rise_pending;
    logic [NUM_SEATS-1:0] r_in_queue;
    logic [SEAT_W-1:0]    r_fifo [0:NUM_SEATS-1];
    logic [SEAT_W-1:0]    r_wr_ptr;
    logic [SEAT_W-1:0]    r_rd_ptr;
    logic [SEAT_W:0]      r_count;
    logic                 r_chime;
    logic [SEAT_W-1:0]    r_cur_seat;
    logic                 r_cur_valid;
    logic [NUM_SEATS-1:0] r_cancel;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_stuck;
    logic                 r_ack_prev;

    logic [NUM_SEATS-1:0] w_candidates;
    logic [NUM_SEATS-1:0] w_push_mask;
    logic [NUM_SEATS-1:0] w_clr_mask;
    logic [SEAT_W-1:0]    w_push_idx;
    logic [SEAT_W-1:0]    w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ack_rise;
    logic                 w_cur_lit;

    assign w_candidates = r_rise_pending & ~r_in_queue;
    assign w_push       = |w_candidates;
    assign w_pop        = (r_state == S_LOAD);
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_ack_rise   = ack_button & ~r_ack_prev;
    assign w_cur_lit    = light_state[r_cur_seat];

    // Descending scan so the lowest-index candidate wins.
    always_comb begin
        w_push_idx = '0;
        for (int i = NUM_SEATS - 1; i >= 0; i--) begin
            if (w_candidates[i]) begin
                w_push_idx = SEAT_W'(i);
            end
        end
        w_push_mask = w_push ? (NUM_SEATS'(1) << w_push_idx) : '0;
    end

    always_comb begin
        w_clr_mask = '0;
        if (r_state == S_LOAD && !light_state[w_head]) begin
            w_clr_mask = NUM_SEATS'(1) << w_head;
        end else if (r_state == S_RETIRE) begin
            w_clr_mask = NUM_SEATS'(1) << r_cur_seat;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_prev         <= '0;
            r_rise_pending <= '0;
            r_in_queue     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_chime        <= 1'b0;
            r_cur_seat     <= '0;
            r_cur_valid    <= 1'b0;
            r_cancel       <= '0;
            r_timer        <= '0;
            r_stuck        <= 1'b0;
            r_ack_prev     <= 1'b0;
        end else begin
            r_prev         <= light_state;
            r_ack_prev     <= ack_button;
            r_rise_pending <= (r_rise_pending & light_state & ~w_push_mask) | (light_state & ~r_prev);
            r_in_queue     <= (r_in_queue | w_push_mask) & ~w_clr_mask;
            r_chime        <= w_push;

            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == SEAT_W'(NUM_SEATS - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == SEAT_W'(NUM_SEATS - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_cur_valid <= 1'b0;
                    if (r_count != '0) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cur_seat <= w_head;
                    if (!light_state[w_head]) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state     <= S_PRESENT;
                        r_cur_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (!w_cur_lit) begin
                        r_state     <= S_RETIRE;
                        r_cur_valid <= 1'b0;
                    end else if (w_ack_rise) begin
                        r_state  <= S_CANCEL;
                        r_cancel <= NUM_SEATS'(1) << r_cur_seat;
                    end
                end
                S_CANCEL: begin
                    r_cancel <= '0;
                    r_timer  <= TMR_W'(WAIT_MAX);
                    r_state  <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    if (!w_cur_lit) begin
                        r_state     <= S_RETIRE;
                        r_cur_valid <= 1'b0;
                    end else if (r_timer <= TMR_W'(1)) begin
                        r_stuck     <= 1'b1;
                        r_state     <= S_RETIRE;
                        r_cur_valid <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RETIRE: begin
                    r_cur_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cancel_pulse  = r_cancel;
    assign current_seat  = r_cur_seat;
    assign current_valid = r_cur_valid;
    assign pending_count = r_count;
    assign chime         = r_chime;
    assign stuck_fault   = r_stuck;

endmodule

// File: doc/fa_attendant_panel.md
Name: fa_attendant_panel

Overview:
Attendant-station end of the flight-attendant call interface. It watches the light_state outputs of NUM_SEATS seat call units (fasystem_bh instances) and queues new calls in arrival order. It presents the oldest call to the attendant and, on acknowledge, drives a one-cycle pulse into that seat's cancel_button input. It then waits for the seat light to go out before retiring the call.

Parameters:
NUM_SEATS, 8, number of seat call units monitored
SEAT_W, 3, seat index width; must satisfy 2**SEAT_W >= NUM_SEATS
WAIT_MAX, 16, cycles allowed in WAIT_CLR for the seat light to drop after a cancel pulse

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
light_state  input  NUM_SEATS  per-seat call light from seat units (bit i = seat i)
ack_button  input  1  attendant acknowledge, already synchronized level; acted on at rising edge only
cancel_pulse  output  NUM_SEATS  one-hot, one-cycle pulse to seat i cancel_button
current_seat  output  SEAT_W  seat index being presented
current_valid  output  1  high while a call is presented/being cleared
pending_count  output  SEAT_W+1  FIFO occupancy, excluding current call
chime  output  1  one-cycle pulse per call enqueued
stuck_fault  output  1  sticky; a seat light did not drop within WAIT_MAX

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, rise_pending/in_queue/prev-light registers 0. A light already high at reset release therefore counts as a new call.
- Rise detect: at an edge where light_state[i]=1 and prev[i]=0, set rise_pending[i]. rise_pending[i] clears when seat i is pushed or when light_state[i] samples 0.
- Enqueue: each cycle, candidates = rise_pending & ~in_queue. Push the lowest-index candidate into the FIFO (depth NUM_SEATS), set in_queue[i], and pulse chime the following cycle.
  - At most one push per cycle. Simultaneous calls are pushed lowest index first on consecutive cycles.
  - in_queue dedupes seats, so the FIFO can never overflow.
- FSM (registered outputs):
  - IDLE: current_valid=0. FIFO non-empty -> LOAD.
  - LOAD: pop head into current_seat.
    - If light_state[seat]=0 (passenger cancelled while queued): clear in_queue[seat], go to IDLE. No pulse.
    - Otherwise -> PRESENT, with current_valid=1 from the next cycle.
  - PRESENT: current_valid=1.
    - If light_state[current_seat] drops -> RETIRE.
    - Otherwise, on ack_button rising edge -> CANCEL.
    - Ack edges in any other state are ignored and not remembered.
  - CANCEL: cancel_pulse[current_seat]=1 for exactly one cycle -> WAIT_CLR; load the timeout counter with WAIT_MAX.
  - WAIT_CLR: on light_state[current_seat]=0 -> RETIRE. If the counter expires, set stuck_fault and go to RETIRE.
  - RETIRE: clear in_queue[current_seat], current_valid=0 -> IDLE.
- Latency: seat light first sampled high at edge k (idle panel, empty FIFO):
  - push at k+1
  - chime high during cycle k+1..k+2
  - LOAD at k+2
  - current_valid=1 after edge k+3
- Push and pop in the same cycle are both honoured; pending_count is unchanged.
- A seat that re-calls while it is current is pushed again only after RETIRE clears its in_queue bit.
- Reset mid-operation: the FIFO is flushed, and any cancel_pulse in flight is truncated to 0 in the cycle after reset is sampled.
- stuck_fault clears only on reset.

Test Plan:
- Reset, then seat 3 light rises at edge k -> chime at k+1, current_seat=3 and current_valid=1 at k+3. An ack edge produces cancel_pulse=8'b0000_1000 for 1 cycle. Light drops 2 cycles later -> current_valid=0, pending_count=0.
- Seats 5 and 1 rise on the same edge -> pushes ordered seat 1 then seat 5, two chimes, pending_count peaks at 2. Service order is 1 then 5.
- Seat 2 queued behind seat 6, then seat 2 light drops before it reaches head -> seat 2 skipped in LOAD, no cancel_pulse[2], panel returns to IDLE.
- Seat 4 is presented and its light drops before ack -> RETIRE with no pulse. An ack pressed afterward in IDLE -> no cancel_pulse.
- Seat 0 acked but its light is held high -> after WAIT_MAX=16 cycles stuck_fault=1 and the call retires. stuck_fault stays 1 until reset.
- Reset asserted during WAIT_CLR with 3 pending -> next cycle: pending_count=0, current_valid=0, cancel_pulse=0, stuck_fault=0.
